// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wshb_arb_pkg;

   localparam int ADR_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   // Enough bits to hold the value TIMEOUT_CYCLES itself.
   function automatic int tmo_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 classic/registered-feedback bus bundle, one per port.
interface wshb_if #(
   parameter int DATA_BYTES = 4
) ();
   logic [wshb_arb_pkg::ADR_W-1:0] adr;
   logic [8*DATA_BYTES-1:0]        dat_ms;
   logic [8*DATA_BYTES-1:0]        dat_sm;
   logic [DATA_BYTES-1:0]          sel;
   logic                           we;
   logic [2:0]                     cti;
   logic [1:0]                     bte;
   logic                           cyc;
   logic                           stb;
   logic                           ack;
   logic                           err;
   logic                           rty;

   modport master (
      output adr, dat_ms, sel, we, cti, bte, cyc, stb,
      input  dat_sm, ack, err, rty
   );

   modport slave (
      input  adr, dat_ms, sel, we, cti, bte, cyc, stb,
      output dat_sm, ack, err, rty
   );
endinterface

// File: rtl/wshb_arb_timeout.sv
// Bus watchdog: flags a granted access that has stalled TIMEOUT_CYCLES
// consecutive cycles without any slave response.
module wshb_arb_timeout
   import wshb_arb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic busy,
   input  logic resp,
   output logic expired
);

   localparam int               CNT_W    = tmo_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt;

   // Down-counter reloaded whenever the stall streak is broken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= CNT_LOAD;
      end else if (!busy || resp) begin
         cnt <= CNT_LOAD;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign expired = busy && (cnt == '0);

endmodule

// File: rtl/wshb_arbiter.sv
// Two-master round-robin Wishbone arbiter with grant held for a whole cyc.
// Optional bus watchdog enabled by defining WSHB_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no grant, shared bus driven to zero
// GNT0  | master 0 owns the shared bus
// GNT1  | master 1 owns the shared bus
module wshb_arbiter
   import wshb_arb_pkg::*;
#(
   parameter int DATA_BYTES     = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic  clk,
   input  logic  rst,
   wshb_if.slave  wshb_m0,
   wshb_if.slave  wshb_m1,
   wshb_if.master wshb_s
);

   arb_state_t state;
   arb_state_t state_nxt;
   logic       last_gnt;
   logic       busy;
   logic       resp;
   logic       expired;
   logic       unused_cfg;

   assign resp = wshb_s.ack | wshb_s.err | wshb_s.rty;
   assign busy = ((state == GNT0) && wshb_m0.cyc && wshb_m0.stb) ||
                 ((state == GNT1) && wshb_m1.cyc && wshb_m1.stb);

`ifdef WSHB_ARB_TIMEOUT_EN
   wshb_arb_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy),
      .resp    (resp),
      .expired (expired)
   );
   assign unused_cfg = ^{DATA_BYTES};
`else
   assign expired    = 1'b0;
   assign unused_cfg = ^{busy, resp, DATA_BYTES, TIMEOUT_CYCLES};
`endif

   // State and round-robin history; master 0 wins the first tie after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         state <= state_nxt;
         if (state_nxt == GNT0) begin
            last_gnt <= 1'b0;
         end else if (state_nxt == GNT1) begin
            last_gnt <= 1'b1;
         end
      end
   end

   // Next-state: hold grant for the whole cyc, hand over directly when possible.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (wshb_m0.cyc && wshb_m1.cyc) begin
               state_nxt = last_gnt ? GNT0 : GNT1;
            end else if (wshb_m0.cyc) begin
               state_nxt = GNT0;
            end else if (wshb_m1.cyc) begin
               state_nxt = GNT1;
            end
         end
         GNT0: begin
            if (expired) begin
               state_nxt = IDLE;
            end else if (!wshb_m0.cyc) begin
               state_nxt = wshb_m1.cyc ? GNT1 : IDLE;
            end
         end
         GNT1: begin
            if (expired) begin
               state_nxt = IDLE;
            end else if (!wshb_m1.cyc) begin
               state_nxt = wshb_m0.cyc ? GNT0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign wshb_m0.dat_sm = wshb_s.dat_sm;
   assign wshb_m1.dat_sm = wshb_s.dat_sm;

   // Bus mux: request side follows the granted master, responses go only to it.
   always_comb begin
      wshb_s.adr    = '0;
      wshb_s.dat_ms = '0;
      wshb_s.sel    = '0;
      wshb_s.we     = 1'b0;
      wshb_s.cti    = '0;
      wshb_s.bte    = '0;
      wshb_s.cyc    = 1'b0;
      wshb_s.stb    = 1'b0;
      wshb_m0.ack   = 1'b0;
      wshb_m0.err   = 1'b0;
      wshb_m0.rty   = 1'b0;
      wshb_m1.ack   = 1'b0;
      wshb_m1.err   = 1'b0;
      wshb_m1.rty   = 1'b0;
      case (state)
         GNT0: begin
            wshb_s.adr    = wshb_m0.adr;
            wshb_s.dat_ms = wshb_m0.dat_ms;
            wshb_s.sel    = wshb_m0.sel;
            wshb_s.we     = wshb_m0.we;
            wshb_s.cti    = wshb_m0.cti;
            wshb_s.bte    = wshb_m0.bte;
            wshb_s.cyc    = wshb_m0.cyc && !expired;
            wshb_s.stb    = wshb_m0.stb && !expired;
            wshb_m0.ack   = wshb_s.ack && !expired;
            wshb_m0.err   = wshb_s.err || expired;
            wshb_m0.rty   = wshb_s.rty && !expired;
         end
         GNT1: begin
            wshb_s.adr    = wshb_m1.adr;
            wshb_s.dat_ms = wshb_m1.dat_ms;
            wshb_s.sel    = wshb_m1.sel;
            wshb_s.we     = wshb_m1.we;
            wshb_s.cti    = wshb_m1.cti;
            wshb_s.bte    = wshb_m1.bte;
            wshb_s.cyc    = wshb_m1.cyc && !expired;
            wshb_s.stb    = wshb_m1.stb && !expired;
            wshb_m1.ack   = wshb_s.ack && !expired;
            wshb_m1.err   = wshb_s.err || expired;
            wshb_m1.rty   = wshb_s.rty && !expired;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/wshb_arbiter.md
WSHB_ARBITER -- requirements
Module: wshb_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_BYTES, default 4, giving the Wishbone data width in bytes for all three bus ports.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the watchdog limit in clock cycles (used only under REQ-024).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock for all logic.
REQ-004 The block SHALL have port rst, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port wshb_m0, wshb_if.slave, DATA_BYTES, requester 0 (higher initial priority, e.g. display reader).
REQ-006 The block SHALL have port wshb_m1, wshb_if.slave, DATA_BYTES, requester 1 (e.g. pixel writer).
REQ-007 The block SHALL have port wshb_s, wshb_if.master, DATA_BYTES, the shared bus toward the memory controller.

Function
REQ-008 The FSM SHALL have the states IDLE, GNT0 and GNT1, held in a registered state variable.
REQ-009 In IDLE, a request from a single master (cyc=1) SHALL move the FSM to that master's GNT state on the next clock edge.
REQ-010 In IDLE with both cyc asserted, the grant SHALL go to the master not recorded in register last_gnt (round-robin).
REQ-011 last_gnt SHALL update to the granted index on every entry into GNT0 or GNT1.
REQ-012 In GNTk the grant SHALL be held while wshb_mk.cyc=1, so that multi-beat and burst cycles (cti/bte) are never split.
REQ-013 In GNTk with wshb_mk.cyc=0, the FSM SHALL move directly to the other GNT state if the other cyc=1, else to IDLE.
REQ-014 Handover SHALL add no dead cycle.
REQ-015 In GNTk, wshb_s adr, dat_ms, sel, we, cti, bte, cyc and stb SHALL combinationally equal those of wshb_mk.
REQ-016 In IDLE, wshb_s.cyc and wshb_s.stb SHALL be 0 and the other wshb_s outputs SHALL be 0.
REQ-017 wshb_s ack, err and rty SHALL be routed only to the granted master; the non-granted master SHALL see ack=err=rty=0 and therefore stalls.
REQ-018 wshb_s.dat_sm SHALL be broadcast to both dat_sm outputs.
REQ-019 Grant latency from the first cyc in IDLE to wshb_s.cyc=1 SHALL be exactly 1 clock.
REQ-020 An ack arriving on the same cycle the granted master drops cyc SHALL be delivered to that master only.

Reset
REQ-021 Asserting rst=0 SHALL asynchronously force state=IDLE and last_gnt=1, so that master 0 wins the first tie.
REQ-022 With rst=0, all wshb_s outputs and all master-side ack/err/rty SHALL be 0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no ack delivered; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-024 With macro WSHB_ARB_TIMEOUT_EN defined, a counter SHALL count consecutive granted cycles with stb=1 and ack=err=rty=0.
REQ-025 Under WSHB_ARB_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES the block SHALL assert err to the granted master for 1 cycle, force wshb_s.cyc=stb=0 in that cycle, and move to IDLE.
REQ-026 Under WSHB_ARB_TIMEOUT_EN, the counter SHALL clear on any ack/err/rty, on a grant change and on reset.
REQ-027 Without WSHB_ARB_TIMEOUT_EN, no counter SHALL exist, the arbiter SHALL never generate err itself, and TIMEOUT_CYCLES SHALL be unused.

Structure
REQ-028 Package wshb_arb_pkg SHALL hold the state enum typedef (IDLE, GNT0, GNT1) and the function computing the timeout counter width ($clog2 of TIMEOUT_CYCLES+1).
REQ-029 The watchdog SHALL be a sub-module, wshb_arb_timeout, instantiated only under WSHB_ARB_TIMEOUT_EN.

Verification
REQ-030 A bench SHALL apply m0 single read, adr=0x100, with the slave acking after 2 cycles, and check wshb_s.cyc=1 one clock after m0.cyc, m0 receiving ack and data 0xDEADBEEF, and m1 seeing ack=0.
REQ-031 A bench SHALL apply m0.cyc and m1.cyc rising in the same cycle after reset and check m0 granted first; after m0 drops cyc, m1 SHALL be granted on the next edge with no IDLE cycle.
REQ-032 A bench SHALL apply three back-to-back simultaneous request rounds and check the grants alternate m0, m1, m0.
REQ-033 A bench SHALL apply an m1 incrementing burst of 8 beats (cti=010, final cti=111) while m0 requests, and check m0 is not granted until m1.cyc=0 after beat 8.
REQ-034 A bench SHALL assert rst=0 mid-burst on beat 3 and check all outputs are 0 immediately (asynchronously), and that after release a fresh m1 request is granted in 1 cycle.
REQ-035 With WSHB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, a bench SHALL run a slave that never acks and check m0 receives err after 16 stalled cycles, wshb_s.cyc drops, and a pending m1 is then granted.
